// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: FSM state encoding and reset-cause bit positions shared with the
// microcontroller status register.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_LOCK = 1;
    localparam int CAUSE_EXT  = 2;
    localparam int CAUSE_SW   = 3;
    localparam int CAUSE_W    = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction

    function automatic logic [CAUSE_W-1:0] cause_bits(input logic lock_lost, input logic ext, input logic sw);
        logic [CAUSE_W-1:0] c;
        c = '0;
        c[CAUSE_LOCK] = lock_lost;
        c[CAUSE_EXT]  = ext;
        c[CAUSE_SW]   = sw;
        return c;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// synchronizer: DEPTH-stage flop chain bringing an asynchronous level into the clk domain.
module synchronizer #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff <= {DEPTH{RESET_VAL}};
        else ff <= {ff[DEPTH-2:0], d};
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock and the reset button, stretches reset, releases
// domains in staged order and keeps a sticky record of what caused the last reset.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DOMAINS = 3,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_GAP   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   ext_rst_n,
    input  logic                   sw_reset_req,
    input  logic                   cause_clear,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_released,
    output logic [CAUSE_W-1:0]     reset_cause
);

    localparam int CW = $clog2(max3(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CW-1:0] FILTER_END = CW'(LOCK_FILTER);
    localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_END    = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DOMAINS - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic               lock_s;
    logic               btn_s;
    logic               ok;
    logic [CAUSE_W-1:0] cause_set;

    synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_lock_sync (
        .clk  (clk),
        .reset(reset),
        .d    (pll_locked),
        .q    (lock_s)
    );

    synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_btn_sync (
        .clk  (clk),
        .reset(reset),
        .d    (ext_rst_n),
        .q    (btn_s)
    );

    assign ok = lock_s && btn_s;
    // Faults only count as causes once qualification has passed; WAIT_LOCK just restarts its filter.
    assign cause_set = (state == ST_HOLD || state == ST_RELEASE || state == ST_RUN)
                     ? cause_bits(!lock_s, !btn_s, state == ST_RUN && sw_reset_req) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_ASSERT;
            cnt          <= '0;
            idx          <= '0;
            domain_rst   <= '1;
            all_released <= 1'b0;
            reset_cause  <= CAUSE_W'(1) << CAUSE_POR;
        end else begin
            reset_cause <= (cause_clear ? '0 : reset_cause) | cause_set;
            case (state)
                ST_ASSERT: begin
                    state <= ST_WAIT_LOCK;
                    cnt   <= ok ? CW'(1) : '0;
                end
                ST_WAIT_LOCK: begin
                    if (!ok) cnt <= '0;
                    else if (cnt == FILTER_END) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                ST_HOLD: begin
                    if (!ok) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_END) begin
                        cnt           <= '0;
                        domain_rst[0] <= 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            state        <= ST_RUN;
                            all_released <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IW'(1);
                        end
                    end else cnt <= cnt + 1'b1;
                end
                ST_RELEASE: begin
                    if (!ok) begin
                        state      <= ST_WAIT_LOCK;
                        cnt        <= '0;
                        idx        <= '0;
                        domain_rst <= '1;
                    end else if (cnt == GAP_END) begin
                        cnt             <= '0;
                        domain_rst[idx] <= 1'b0;
                        idx             <= idx == LAST_IDX ? '0 : idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state        <= ST_RUN;
                            all_released <= 1'b1;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                ST_RUN: begin
                    if (|cause_set) begin
                        state        <= ST_ASSERT;
                        cnt          <= '0;
                        idx          <= '0;
                        domain_rst   <= '1;
                        all_released <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_ASSERT;
                    domain_rst <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random stimulus against a progress-count model.
module tb_reset_sequencer;

    localparam int S   = 2;
    localparam int N   = 3;
    localparam int LF  = 4;
    localparam int HC  = 8;
    localparam int GAP = 3;
    // Qualified cycles needed from the first ok edge to each domain's release.
    localparam int T0  = LF + HC + 2;
    localparam int TL  = T0 + (N - 1) * GAP;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pll_locked = 1'b0;
    logic         ext_rst_n = 1'b1;
    logic         sw_reset_req = 1'b0;
    logic         cause_clear = 1'b0;
    logic [N-1:0] domain_rst;
    logic         all_released;
    logic [3:0]   reset_cause;

    int n_checks = 0;
    int n_errors = 0;

    bit           lk_q[$];
    bit           bt_q[$];
    int           p;
    bit           m_run;
    bit           m_pending;
    logic [N-1:0] m_dom;
    logic         m_all;
    logic [3:0]   m_cause;
    int           fall_at[N];
    int           all_at;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(S),
        .NUM_DOMAINS(N),
        .LOCK_FILTER(LF),
        .HOLD_CYCLES(HC),
        .STAGE_GAP  (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .ext_rst_n   (ext_rst_n),
        .sw_reset_req(sw_reset_req),
        .cause_clear (cause_clear),
        .domain_rst  (domain_rst),
        .all_released(all_released),
        .reset_cause (reset_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        lk_q = {};
        bt_q = {};
        repeat (S) begin
            lk_q.push_back(1'b0);
            bt_q.push_back(1'b1);
        end
        p         = 0;
        m_run     = 1'b0;
        m_pending = 1'b1;
        m_dom     = '1;
        m_all     = 1'b0;
        m_cause   = 4'b0001;
    endtask

    // p counts consecutive qualified edges; release points are fixed offsets of p.
    task automatic model_edge();
        bit lk, bt, ok;
        logic [3:0] flt, set;
        if (reset) return;
        lk = lk_q.pop_front();
        bt = bt_q.pop_front();
        lk_q.push_back(pll_locked);
        bt_q.push_back(ext_rst_n);
        ok  = lk && bt;
        flt = {1'b0, !bt, !lk, 1'b0};
        set = '0;
        if (m_run) begin
            set = flt | {sw_reset_req, 3'b000};
            if (set != 0) begin
                m_run     = 1'b0;
                m_pending = 1'b1;
                p         = 0;
            end
        end else if (m_pending) begin
            m_pending = 1'b0;
            p = ok ? 1 : 0;
        end else if (!ok) begin
            if (p > LF) set = flt;
            p = 0;
        end else begin
            p++;
            if (p >= TL) m_run = 1'b1;
        end
        m_cause = (cause_clear ? 4'b0000 : m_cause) | set;
        for (int k = 0; k < N; k++) m_dom[k] = !(m_run || (!m_pending && p >= T0 + k * GAP));
        m_all = m_run;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("domain_rst", domain_rst, m_dom);
        check("all_released", all_released, m_all);
        check("reset_cause", reset_cause, m_cause);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        m_reset();
        #1;
        check("async_domain_rst", domain_rst, {N{1'b1}});
        check("async_all_released", all_released, 0);
        check("async_cause", reset_cause, 4'b0001);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic measure(input int budget);
        for (int k = 0; k < N; k++) fall_at[k] = -1;
        all_at = -1;
        for (int e = 0; e < budget; e++) begin
            tick();
            sw_reset_req = 1'b0;
            cause_clear  = 1'b0;
            for (int k = 0; k < N; k++) if (fall_at[k] < 0 && !domain_rst[k]) fall_at[k] = e;
            if (all_at < 0 && all_released) all_at = e;
        end
    endtask

    task automatic check_release(input string tag, input int base);
        for (int k = 0; k < N; k++) check({tag, "_fall"}, fall_at[k], base + k * GAP);
        check({tag, "_all"}, all_at, base + (N - 1) * GAP);
    endtask

    initial begin
        int w;
        int bad;
        @(negedge clk);

        do_reset();
        repeat (3) tick();
        pll_locked = 1'b1;
        measure(40);
        check_release("powerup", S + LF + HC + 1);
        check("powerup_cause", reset_cause, 4'b0001);

        do_reset();
        repeat (9) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        measure(40);
        check_release("glitch", S + LF + HC + 1);
        check("glitch_cause", reset_cause, 4'b0011);

        sw_reset_req = 1'b1;
        measure(40);
        check_release("sw", 1 + LF + HC + 1);
        check("sw_cause_bit", reset_cause[3], 1);

        ext_rst_n = 1'b0;
        repeat (S) tick();
        sw_reset_req = 1'b1;
        cause_clear  = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        cause_clear  = 1'b0;
        ext_rst_n    = 1'b1;
        check("simul_cause", reset_cause, 4'b1100);

        w = 0;
        while (!(!domain_rst[0] && domain_rst[N-1]) && w < 100) begin
            tick();
            w++;
        end
        check("midrel_reached", w < 100, 1);
        do_reset();
        measure(40);
        check_release("midrel", S + LF + HC + 1);

        ext_rst_n = 1'b0;
        bad = 0;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (e >= S && domain_rst != {N{1'b1}}) bad++;
        end
        check("btn_hold_released", bad, 0);
        ext_rst_n = 1'b1;
        measure(40);
        check_release("btn", S + LF + HC + 1);
        check("btn_cause_bit", reset_cause[2], 1);

        for (int i = 0; i < 3000; i++) begin
            pll_locked   = ($urandom_range(0, 199) != 0);
            ext_rst_n    = ($urandom_range(0, 299) != 0);
            sw_reset_req = ($urandom_range(0, 49) == 0);
            cause_clear  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
            sw_reset_req = 1'b0;
            cause_clear  = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
